// File: rtl/wb_regfile_p.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile_p
// Description : Y86-64 write-back stage. Owns the W pipeline register (stall /
//               bubble control), the architectural register file with two
//               write ports and W-stage bypass on two decode read ports, a
//               raw debug read port, a sticky halt flag and a saturating
//               retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile_p #(
   parameter int                DATA_W    = 64,
   parameter int                NREG      = 15,
   parameter int                RADDR_W   = 4,
   parameter int                CNT_W     = 32,
   parameter logic [DATA_W-1:0] RESET_RSP = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               W_stall,
   input  logic               W_bubble,
   input  logic [1:0]         m_stat,
   input  logic [3:0]         M_icode,
   input  logic [DATA_W-1:0]  M_valE,
   input  logic [DATA_W-1:0]  m_valM,
   input  logic [RADDR_W-1:0] M_dstE,
   input  logic [RADDR_W-1:0] M_dstM,
   input  logic [RADDR_W-1:0] d_srcA,
   input  logic [RADDR_W-1:0] d_srcB,
   input  logic [RADDR_W-1:0] dbg_addr,
   output logic [1:0]         W_stat,
   output logic [3:0]         W_icode,
   output logic [DATA_W-1:0]  W_valE,
   output logic [DATA_W-1:0]  W_valM,
   output logic [RADDR_W-1:0] W_dstE,
   output logic [RADDR_W-1:0] W_dstM,
   output logic [DATA_W-1:0]  d_rvalA,
   output logic [DATA_W-1:0]  d_rvalB,
   output logic [DATA_W-1:0]  dbg_data,
   output logic               halted,
   output logic [CNT_W-1:0]   retired
);

   localparam logic [1:0]         c_STAT_AOK  = 2'd0;
   localparam logic [3:0]         c_ICODE_NOP = 4'd1;
   localparam logic [RADDR_W-1:0] c_RNONE     = {RADDR_W{1'b1}};
   localparam logic [CNT_W-1:0]   c_CNT_MAX   = {CNT_W{1'b1}};
   localparam int                 c_RSP_IDX   = 4;
   localparam int                 c_NPORTS    = 3;
   localparam int                 c_DBG_PORT  = 2;

   // W pipeline register
   logic [1:0]         r_w_stat;
   logic [3:0]         r_w_icode;
   logic [DATA_W-1:0]  r_w_valE;
   logic [DATA_W-1:0]  r_w_valM;
   logic [RADDR_W-1:0] r_w_dstE;
   logic [RADDR_W-1:0] r_w_dstM;

   // Architectural state
   logic [DATA_W-1:0]  r_regs [NREG];
   logic               r_halted;
   logic [CNT_W-1:0]   r_retired;

   // Commit qualifiers derived from the W contents before the edge
   logic w_commit;
   logic w_wr_e;
   logic w_wr_m;
   logic w_retire;

   // Read-port plumbing: ports 0/1 are decode A/B, port 2 is debug
   logic [RADDR_W-1:0] w_rd_addr [c_NPORTS];
   logic [DATA_W-1:0]  w_rd_data [c_NPORTS];

   // An address names a real register only if it is not RNONE and below NREG
   function automatic logic f_valid(input logic [RADDR_W-1:0] a);
      return (a != c_RNONE) && (int'(a) < NREG);
   endfunction

   assign w_commit = !r_halted && (r_w_stat == c_STAT_AOK);
   assign w_wr_e   = w_commit && f_valid(r_w_dstE);
   assign w_wr_m   = w_commit && f_valid(r_w_dstM);
   assign w_retire = w_commit && (r_w_icode != c_ICODE_NOP) && !W_stall;

   // W register: reset and bubble both load a nop; bubble beats stall
   always_ff @(posedge clk) begin
      if (rst || W_bubble) begin
         r_w_stat  <= c_STAT_AOK;
         r_w_icode <= c_ICODE_NOP;
         r_w_valE  <= '0;
         r_w_valM  <= '0;
         r_w_dstE  <= c_RNONE;
         r_w_dstM  <= c_RNONE;
      end else if (!W_stall) begin
         r_w_stat  <= m_stat;
         r_w_icode <= M_icode;
         r_w_valE  <= M_valE;
         r_w_valM  <= m_valM;
         r_w_dstE  <= M_dstE;
         r_w_dstM  <= M_dstM;
      end
   end

   // Register file writes; valM port takes precedence when both target one register
   always_ff @(posedge clk) begin
      for (int i = 0; i < NREG; i++) begin
         if (rst) begin
            r_regs[i] <= (i == c_RSP_IDX) ? RESET_RSP : '0;
         end else if (w_wr_m && (r_w_dstM == RADDR_W'(i))) begin
            r_regs[i] <= r_w_valM;
         end else if (w_wr_e && (r_w_dstE == RADDR_W'(i))) begin
            r_regs[i] <= r_w_valE;
         end
      end
   end

   // Sticky halt flag and saturating retired-instruction counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_halted  <= 1'b0;
         r_retired <= '0;
      end else begin
         if (r_w_stat != c_STAT_AOK) begin
            r_halted <= 1'b1;
         end
         if (w_retire && (r_retired != c_CNT_MAX)) begin
            r_retired <= r_retired + 1'b1;
         end
      end
   end

   assign w_rd_addr[0]          = d_srcA;
   assign w_rd_addr[1]          = d_srcB;
   assign w_rd_addr[c_DBG_PORT] = dbg_addr;

   for (genvar p = 0; p < c_NPORTS; p++) begin : g_rd_port
      logic [DATA_W-1:0] w_data;

      // Register lookup, then W-stage bypass (valM over valE) on decode ports only
      always_comb begin
         w_data = '0;
         if (f_valid(w_rd_addr[p])) begin
            for (int i = 0; i < NREG; i++) begin
               if (w_rd_addr[p] == RADDR_W'(i)) begin
                  w_data = r_regs[i];
               end
            end
            if ((p != c_DBG_PORT) && w_commit) begin
               if (w_rd_addr[p] == r_w_dstM) begin
                  w_data = r_w_valM;
               end else if (w_rd_addr[p] == r_w_dstE) begin
                  w_data = r_w_valE;
               end
            end
         end
      end

      assign w_rd_data[p] = w_data;
   end

   assign d_rvalA  = w_rd_data[0];
   assign d_rvalB  = w_rd_data[1];
   assign dbg_data = w_rd_data[c_DBG_PORT];

   assign W_stat   = r_w_stat;
   assign W_icode  = r_w_icode;
   assign W_valE   = r_w_valE;
   assign W_valM   = r_w_valM;
   assign W_dstE   = r_w_dstE;
   assign W_dstM   = r_w_dstM;
   assign halted   = r_halted;
   assign retired  = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile_p.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_regfile_p
// Description : Self-checking bench for wb_regfile_p (NREG=14, CNT_W=3,
//               RESET_RSP=0x100). Directed scenarios plus randomized traffic
//               compared against an architectural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_regfile_p;

   localparam int          c_NREG  = 14;
   localparam int          c_CMAX  = 7;
   localparam logic [63:0] c_RSP   = 64'h100;

   logic        clk = 1'b0;
   logic        rst, W_stall, W_bubble;
   logic [1:0]  m_stat;
   logic [3:0]  M_icode;
   logic [63:0] M_valE, m_valM;
   logic [3:0]  M_dstE, M_dstM, d_srcA, d_srcB, dbg_addr;
   logic [1:0]  W_stat;
   logic [3:0]  W_icode;
   logic [63:0] W_valE, W_valM;
   logic [3:0]  W_dstE, W_dstM;
   logic [63:0] d_rvalA, d_rvalB, dbg_data;
   logic        halted;
   logic [2:0]  retired;

   int n_checks = 0;
   int n_errors = 0;

   wb_regfile_p #(
      .DATA_W(64), .NREG(c_NREG), .RADDR_W(4), .CNT_W(3), .RESET_RSP(c_RSP)
   ) dut (
      .clk(clk), .rst(rst), .W_stall(W_stall), .W_bubble(W_bubble),
      .m_stat(m_stat), .M_icode(M_icode), .M_valE(M_valE), .m_valM(m_valM),
      .M_dstE(M_dstE), .M_dstM(M_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB),
      .dbg_addr(dbg_addr), .W_stat(W_stat), .W_icode(W_icode),
      .W_valE(W_valE), .W_valM(W_valM), .W_dstE(W_dstE), .W_dstM(W_dstM),
      .d_rvalA(d_rvalA), .d_rvalB(d_rvalB), .dbg_data(dbg_data),
      .halted(halted), .retired(retired)
   );

   always #5 clk = ~clk;

   // ---------------- architectural reference model ----------------
   typedef struct {
      logic [1:0]  stat;
      logic [3:0]  icode;
      logic [63:0] valE, valM;
      logic [3:0]  dstE, dstM;
   } wrec_t;

   wrec_t       mw;
   logic [63:0] mregs [c_NREG];
   bit          mhalted;
   int          mretired;

   function automatic wrec_t bubble_rec();
      wrec_t b;
      b.stat = 2'd0; b.icode = 4'd1; b.valE = '0; b.valM = '0;
      b.dstE = 4'hF; b.dstM = 4'hF;
      return b;
   endfunction

   // Advance the model by one clock edge using the inputs presented at it
   function automatic void model_edge();
      bit ok;
      if (rst) begin
         mw = bubble_rec();
         for (int i = 0; i < c_NREG; i++) mregs[i] = (i == 4) ? c_RSP : 64'd0;
         mhalted = 0;
         mretired = 0;
         return;
      end
      ok = !mhalted && (mw.stat == 2'd0);
      if (ok && int'(mw.dstE) < c_NREG) mregs[mw.dstE] = mw.valE;
      if (ok && int'(mw.dstM) < c_NREG) mregs[mw.dstM] = mw.valM;
      if (ok && mw.icode != 4'd1 && !W_stall && mretired < c_CMAX) mretired++;
      if (mw.stat != 2'd0) mhalted = 1;
      if (W_bubble) mw = bubble_rec();
      else if (!W_stall) begin
         mw.stat = m_stat; mw.icode = M_icode; mw.valE = M_valE;
         mw.valM = m_valM; mw.dstE = M_dstE;   mw.dstM = M_dstM;
      end
   endfunction

   function automatic logic [63:0] model_read(input logic [3:0] a, input bit byp);
      if (int'(a) >= c_NREG) return 64'd0;
      if (byp && !mhalted && mw.stat == 2'd0) begin
         if (a == mw.dstM) return mw.valM;
         if (a == mw.dstE) return mw.valE;
      end
      return mregs[a];
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drive_idle();
      W_stall = 0; W_bubble = 0; m_stat = 2'd0; M_icode = 4'd1;
      M_valE = '0; m_valM = '0; M_dstE = 4'hF; M_dstM = 4'hF;
   endtask

   task automatic drive_instr(input logic [1:0] st, input logic [3:0] ic,
                              input logic [63:0] ve, input logic [63:0] vm,
                              input logic [3:0] de, input logic [3:0] dm);
      m_stat = st; M_icode = ic; M_valE = ve; m_valM = vm; M_dstE = de; M_dstM = dm;
   endtask

   task automatic do_reset();
      drive_idle();
      rst = 1;
      tick();
      tick();
      rst = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      dbg_addr = 4'd4; #1;
      n_checks++; if (dbg_data !== 64'h100) begin n_errors++; $display("FAIL reset_rsp: got %h want %h", dbg_data, 64'h100); end
      dbg_addr = 4'd0; #1;
      n_checks++; if (dbg_data !== 64'h0) begin n_errors++; $display("FAIL reset_r0: got %h want 0", dbg_data); end
      n_checks++; if (W_icode !== 4'd1) begin n_errors++; $display("FAIL reset_icode: got %h want 1", W_icode); end
      n_checks++; if (W_dstE !== 4'hF || W_dstM !== 4'hF) begin n_errors++; $display("FAIL reset_dst: got %h/%h want f/f", W_dstE, W_dstM); end
      n_checks++; if (W_stat !== 2'd0 || W_valE !== 64'd0 || W_valM !== 64'd0) begin n_errors++; $display("FAIL reset_wvals: got stat %h valE %h valM %h want zeros", W_stat, W_valE, W_valM); end
      n_checks++; if (halted !== 1'b0 || retired !== 3'd0) begin n_errors++; $display("FAIL reset_status: got halted %b retired %0d want 0/0", halted, retired); end
   endtask

   task automatic test_write_bypass();
      do_reset();
      drive_instr(2'd0, 4'd3, 64'h55, 64'h0, 4'd3, 4'hF);
      tick();
      drive_idle();
      d_srcA = 4'd3; dbg_addr = 4'd3; #1;
      n_checks++; if (d_rvalA !== 64'h55) begin n_errors++; $display("FAIL bypass_valE: got %h want 55", d_rvalA); end
      n_checks++; if (dbg_data !== 64'h0) begin n_errors++; $display("FAIL dbg_not_bypassed: got %h want 0", dbg_data); end
      tick();
      n_checks++; if (dbg_data !== 64'h55) begin n_errors++; $display("FAIL reg3_written: got %h want 55", dbg_data); end
      n_checks++; if (retired !== 3'd1) begin n_errors++; $display("FAIL retired_one: got %0d want 1", retired); end
   endtask

   task automatic test_dual_write();
      do_reset();
      drive_instr(2'd0, 4'hB, 64'h10, 64'h20, 4'd4, 4'd4);
      tick();
      d_srcA = 4'd4; #1;
      n_checks++; if (d_rvalA !== 64'h20) begin n_errors++; $display("FAIL bypass_same_dst: got %h want 20", d_rvalA); end
      drive_instr(2'd0, 4'd5, 64'd7, 64'd9, 4'd1, 4'd2);
      tick();
      drive_idle();
      d_srcA = 4'd1; d_srcB = 4'd2; #1;
      n_checks++; if (d_rvalA !== 64'd7 || d_rvalB !== 64'd9) begin n_errors++; $display("FAIL bypass_dual: got %h/%h want 7/9", d_rvalA, d_rvalB); end
      tick();
      dbg_addr = 4'd4; #1;
      n_checks++; if (dbg_data !== 64'h20) begin n_errors++; $display("FAIL reg4_valM_wins: got %h want 20", dbg_data); end
      dbg_addr = 4'd1; #1;
      n_checks++; if (dbg_data !== 64'd7) begin n_errors++; $display("FAIL reg1_valE: got %h want 7", dbg_data); end
      dbg_addr = 4'd2; #1;
      n_checks++; if (dbg_data !== 64'd9) begin n_errors++; $display("FAIL reg2_valM: got %h want 9", dbg_data); end
   endtask

   task automatic test_stall_bubble();
      do_reset();
      drive_instr(2'd0, 4'd6, 64'h77, 64'h0, 4'd7, 4'hF);
      tick();
      W_stall = 1;
      drive_instr(2'd0, 4'd6, 64'h88, 64'h0, 4'd8, 4'hF);
      for (int k = 0; k < 3; k++) begin
         tick();
         n_checks++; if (W_valE !== 64'h77 || W_dstE !== 4'd7 || W_icode !== 4'd6) begin n_errors++; $display("FAIL stall_hold[%0d]: got valE %h dstE %h icode %h want 77/7/6", k, W_valE, W_dstE, W_icode); end
         n_checks++; if (retired !== 3'd0) begin n_errors++; $display("FAIL stall_no_retire[%0d]: got %0d want 0", k, retired); end
      end
      W_stall = 0;
      drive_idle();
      tick();
      dbg_addr = 4'd7; #1;
      n_checks++; if (retired !== 3'd1) begin n_errors++; $display("FAIL stall_retire_once: got %0d want 1", retired); end
      n_checks++; if (dbg_data !== 64'h77) begin n_errors++; $display("FAIL stall_reg7: got %h want 77", dbg_data); end
      drive_instr(2'd0, 4'd6, 64'h88, 64'h0, 4'd8, 4'hF);
      tick();
      W_stall = 1; W_bubble = 1;
      tick();
      n_checks++; if (W_icode !== 4'd1 || W_dstE !== 4'hF || W_valE !== 64'd0) begin n_errors++; $display("FAIL bubble_wins: got icode %h dstE %h valE %h want 1/f/0", W_icode, W_dstE, W_valE); end
      n_checks++; if (retired !== 3'd1) begin n_errors++; $display("FAIL bubble_stalled_no_retire: got %0d want 1", retired); end
      drive_idle();
      dbg_addr = 4'd8; #1;
      n_checks++; if (dbg_data !== 64'h88) begin n_errors++; $display("FAIL bubble_reg8: got %h want 88", dbg_data); end
   endtask

   task automatic test_halt();
      do_reset();
      drive_instr(2'd1, 4'd0, 64'hAA, 64'h0, 4'd5, 4'hF);
      tick();
      d_srcA = 4'd5; #1;
      n_checks++; if (W_stat !== 2'd1 || halted !== 1'b0) begin n_errors++; $display("FAIL halt_pending: got stat %h halted %b want 1/0", W_stat, halted); end
      n_checks++; if (d_rvalA !== 64'd0) begin n_errors++; $display("FAIL halt_no_bypass: got %h want 0", d_rvalA); end
      drive_instr(2'd0, 4'd3, 64'h66, 64'h0, 4'd6, 4'hF);
      tick();
      d_srcA = 4'd6; #1;
      n_checks++; if (halted !== 1'b1) begin n_errors++; $display("FAIL halt_set: got %b want 1", halted); end
      n_checks++; if (d_rvalA !== 64'd0) begin n_errors++; $display("FAIL halted_no_bypass: got %h want 0", d_rvalA); end
      drive_idle();
      tick();
      dbg_addr = 4'd5; #1;
      n_checks++; if (dbg_data !== 64'd0) begin n_errors++; $display("FAIL halt_reg5: got %h want 0", dbg_data); end
      dbg_addr = 4'd6; #1;
      n_checks++; if (dbg_data !== 64'd0 || retired !== 3'd0) begin n_errors++; $display("FAIL halt_reg6_blocked: got %h retired %0d want 0/0", dbg_data, retired); end
      do_reset();
      n_checks++; if (halted !== 1'b0) begin n_errors++; $display("FAIL halt_cleared: got %b want 0", halted); end
   endtask

   task automatic test_saturation_range();
      do_reset();
      for (int k = 1; k <= 10; k++) begin
         if (k <= 9) drive_instr(2'd0, 4'd6, 64'd0, 64'd0, 4'hF, 4'hF);
         else drive_idle();
         tick();
         n_checks++; if (int'(retired) !== ((k - 1 > 7) ? 7 : k - 1)) begin n_errors++; $display("FAIL retired_sat[%0d]: got %0d want %0d", k, retired, (k - 1 > 7) ? 7 : k - 1); end
      end
      drive_instr(2'd0, 4'd3, 64'hDEAD, 64'hBEEF, 4'hE, 4'hD);
      tick();
      drive_idle();
      d_srcA = 4'hE; d_srcB = 4'hD; #1;
      n_checks++; if (d_rvalA !== 64'd0) begin n_errors++; $display("FAIL range_read_e: got %h want 0", d_rvalA); end
      n_checks++; if (d_rvalB !== 64'hBEEF) begin n_errors++; $display("FAIL top_reg_bypass: got %h want beef", d_rvalB); end
      tick();
      for (int a = 0; a < 16; a++) begin
         logic [63:0] exp;
         dbg_addr = 4'(a); #1;
         exp = (a == 4) ? c_RSP : (a == 13) ? 64'hBEEF : 64'd0;
         n_checks++; if (dbg_data !== exp) begin n_errors++; $display("FAIL range_dbg[%0d]: got %h want %h", a, dbg_data, exp); end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 400; k++) begin
         rst      = ($urandom_range(99) < 2);
         W_stall  = ($urandom_range(99) < 20);
         W_bubble = ($urandom_range(99) < 10);
         m_stat   = ($urandom_range(99) < 4) ? 2'($urandom_range(3, 1)) : 2'd0;
         M_icode  = 4'($urandom_range(15));
         M_valE   = {$urandom, $urandom};
         m_valM   = {$urandom, $urandom};
         M_dstE   = 4'($urandom_range(15));
         M_dstM   = ($urandom_range(3) == 0) ? M_dstE : 4'($urandom_range(15));
         d_srcA   = 4'($urandom_range(15));
         d_srcB   = ($urandom_range(1) == 0) ? M_dstE : 4'($urandom_range(15));
         dbg_addr = 4'($urandom_range(15));
         tick();
         n_checks++; if (W_stat !== mw.stat || W_icode !== mw.icode || W_valE !== mw.valE || W_valM !== mw.valM || W_dstE !== mw.dstE || W_dstM !== mw.dstM) begin
            n_errors++; $display("FAIL rand_wreg[%0d]: got %h %h %h %h %h %h want %h %h %h %h %h %h", k, W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM, mw.stat, mw.icode, mw.valE, mw.valM, mw.dstE, mw.dstM); end
         n_checks++; if (d_rvalA !== model_read(d_srcA, 1) || d_rvalB !== model_read(d_srcB, 1)) begin
            n_errors++; $display("FAIL rand_read[%0d]: got %h/%h want %h/%h", k, d_rvalA, d_rvalB, model_read(d_srcA, 1), model_read(d_srcB, 1)); end
         n_checks++; if (dbg_data !== model_read(dbg_addr, 0)) begin
            n_errors++; $display("FAIL rand_dbg[%0d]: got %h want %h", k, dbg_data, model_read(dbg_addr, 0)); end
         n_checks++; if (halted !== mhalted || int'(retired) !== mretired) begin
            n_errors++; $display("FAIL rand_status[%0d]: got halted %b retired %0d want %b/%0d", k, halted, retired, mhalted, mretired); end
      end
      rst = 0;
      drive_idle();
   endtask

   initial begin
      rst = 1; d_srcA = 4'hF; d_srcB = 4'hF; dbg_addr = 4'd0;
      drive_idle();
      test_reset();
      test_write_bypass();
      test_dual_write();
      test_stall_bubble();
      test_halt();
      test_saturation_range();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
`default_nettype wire

// File: doc/wb_regfile_p.md
Name: wb_regfile_p

Overview:
Parametrised write-back stage and register file for the Y86-64 pipeline. It replaces the fixed-width write-back block with one that owns the W pipeline register (with stall and bubble control) and the architectural register file. The register file has two write ports (dstE, dstM), two decode read ports with internal W-stage bypass, and a debug read port. It also keeps a sticky halt/exception status and a retired-instruction counter. It sits between the memory stage and decode.

Parameters:
DATA_W, 64, register and value width
NREG, 15, number of architectural registers; addresses 0..NREG-1 are valid
RADDR_W, 4, register address width; all-ones (4'hF) is RNONE
CNT_W, 32, retired-instruction counter width
RESET_RSP, 0, reset value of register 4 (%rsp); all other registers reset to 0

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
W_stall  in  1  hold W register
W_bubble  in  1  load bubble into W register
m_stat  in  2  status from memory stage (0 AOK, 1 HLT, 2 ADR, 3 INS)
M_icode  in  4  icode from memory stage
M_valE  in  DATA_W  ALU result
m_valM  in  DATA_W  memory read data
M_dstE  in  RADDR_W  E destination
M_dstM  in  RADDR_W  M destination
d_srcA  in  RADDR_W  decode read address A
d_srcB  in  RADDR_W  decode read address B
dbg_addr  in  RADDR_W  debug read address
W_stat  out  2  latched status
W_icode  out  4  latched icode
W_valE  out  DATA_W  latched valE
W_valM  out  DATA_W  latched valM
W_dstE  out  RADDR_W  latched dstE
W_dstM  out  RADDR_W  latched dstM
d_rvalA  out  DATA_W  read data A, after bypass
d_rvalB  out  DATA_W  read data B, after bypass
dbg_data  out  DATA_W  raw register contents, no bypass
halted  out  1  sticky: a non-AOK W_stat has been seen
retired  out  CNT_W  retired-instruction count

Behaviour:
- All state changes on the rising edge of clk. rst is synchronous and active-high, and has priority over everything.
- Reset values:
  - W register = bubble: W_stat=0, W_icode=1 (nop), W_valE=W_valM=0, W_dstE=W_dstM=RNONE.
  - All registers 0, except reg 4 = RESET_RSP.
  - halted=0, retired=0.
  - A reset in the middle of a run discards the pending W contents with no write.
- W register update, in priority order:
  - rst: load bubble.
  - W_bubble: load bubble. Bubble wins if W_stall is also asserted.
  - W_stall: hold all W fields.
  - Otherwise: load m_stat, M_icode, M_valE, m_valM, M_dstE, M_dstM.
- Register writes happen at the same edge, using the W fields as they stand before that edge.
- A write occurs only when !rst, halted=0 and W_stat=AOK.
  - dstE <- W_valE if W_dstE<NREG.
  - dstM <- W_valM if W_dstM<NREG.
  - If W_dstE==W_dstM (popq %rsp case), valM is the value stored.
  - Addresses >=NREG other than RNONE are ignored: no write, no error.
  - While W_stall holds a valid AOK instruction, the same write repeats each cycle. This is idempotent and allowed.
- Read ports (A and B identical), combinational:
  - src=RNONE or src>=NREG: return 0.
  - Else if W_stat=AOK, halted=0 and src==W_dstM: return W_valM.
  - Else under the same conditions, if src==W_dstE: return W_valE.
  - Else return the register contents.
  - dbg_data is never bypassed; out-of-range addresses return 0.
- halted:
  - Set at the edge where W_stat!=AOK is present; it becomes 1 one cycle after W_stat goes non-AOK.
  - Cleared only by rst.
  - Once set, all writes and bypass are blocked.
- retired:
  - Increments at an edge when !rst, halted=0, W_stat=AOK, W_icode!=1 and W_stall=0.
  - Saturates at all-ones and does not wrap.
  - Stalled cycles count once, on the edge where the instruction leaves W.
- Latency: an M-stage value is visible on W_* one cycle later. It is visible in dbg_data two cycles later, and through the bypass on d_rval one cycle later.

Test Plan:
- Reset: hold rst 2 cycles with RESET_RSP=0x100 -> W_icode=1, W_dstE=W_dstM=0xF, dbg_data(4)=0x100, dbg_data(0)=0, halted=0, retired=0.
- Write and bypass: irmovq-style input (M_dstE=3, M_valE=0x55, M_dstM=0xF, m_stat=0, M_icode=3), then d_srcA=3 -> d_rvalA=0x55 one cycle later via bypass; dbg_data(3)=0x55 the cycle after; retired=1.
- Dual-write conflict: M_dstE=4, M_valE=0x10, M_dstM=4, m_valM=0x20 -> reg 4=0x20. Also M_dstE=1, M_valE=7 with M_dstM=2, m_valM=9 -> reg1=7, reg2=9.
- Stall/bubble: assert W_stall for 3 cycles with new M inputs -> W fields unchanged, retired increments only once. W_stall=W_bubble=1 -> bubble loaded.
- Halt: feed m_stat=1 (HLT) with M_dstE=5, M_valE=0xAA -> reg5 unchanged, halted=1 one cycle after W_stat=1. A following AOK write to reg 6 is blocked; rst clears halted.
- Saturation and range: CNT_W=3, retire 9 instructions -> retired=7. A write to dstE=0xE with NREG=14 -> no register changes; d_srcA=0xE -> 0.
